// File: rtl/sbox_builder_pkg.sv
// rtl/sbox_builder_pkg.sv - shared types, defaults and helpers for the S-box builder
// Contents: state_t (IDLE/FILL/DONE/FAIL), default parameter constants, depth().
package sbox_builder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2,
        FAIL = 2'd3
    } state_t;

    localparam int DEF_SAMPLE_W  = 32;
    localparam int DEF_SYM_W     = 8;
    localparam int DEF_LSB_SEL   = 0;
    localparam int DEF_TRY_W     = 16;
    localparam int DEF_MAX_TRIES = 8192;

    // Number of table entries for a given symbol width.
    function automatic int depth(input int sym_w);
        return 1 << sym_w;
    endfunction

endpackage

// File: rtl/sbox_seen_map.sv
// rtl/sbox_seen_map.sv - one-bit-per-symbol bitmap of symbols already placed in the table
// Ports: clk, rst (async, active-high); clear (single-cycle wipe, wins over set);
//        set_en (mark sym as seen); sym (symbol under test/set); hit (seen[sym], combinational).
module sbox_seen_map
    import sbox_builder_pkg::*;
#(
    parameter int SYM_W = DEF_SYM_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             set_en,
    input  logic [SYM_W-1:0] sym,
    output logic             hit
);

    localparam int N = depth(SYM_W);

    logic [N-1:0] seen;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seen <= '0;
        end else if (clear) begin
            seen <= '0;
        end else if (set_en) begin
            seen[sym] <= 1'b1;
        end
    end

    assign hit = seen[sym];

endmodule

// File: rtl/sbox_builder.sv
// rtl/sbox_builder.sv - builds a 2^SYM_W permutation table from a stream of chaotic samples
// Ports: clk, rst (async, active-high); start (build pulse); in_valid/in_data/in_ready (sample stream);
//        lookup_addr/lookup_data (registered table read); busy, done, fail (status levels);
//        fill_count (unique entries written); tries (samples accepted this build).
// Optional: SBOX_INV_EN adds inv_lookup_addr/inv_lookup_data, a registered read of the inverse table.
module sbox_builder
    import sbox_builder_pkg::*;
#(
    parameter int SAMPLE_W  = DEF_SAMPLE_W,
    parameter int SYM_W     = DEF_SYM_W,
    parameter int LSB_SEL   = DEF_LSB_SEL,
    parameter int TRY_W     = DEF_TRY_W,
    parameter int MAX_TRIES = DEF_MAX_TRIES
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                in_valid,
    input  logic [SAMPLE_W-1:0] in_data,
    output logic                in_ready,
    input  logic [SYM_W-1:0]    lookup_addr,
    output logic [SYM_W-1:0]    lookup_data,
    output logic                busy,
    output logic                done,
    output logic                fail,
    output logic [SYM_W:0]      fill_count,
    output logic [TRY_W-1:0]    tries
`ifdef SBOX_INV_EN
    ,
    input  logic [SYM_W-1:0]    inv_lookup_addr,
    output logic [SYM_W-1:0]    inv_lookup_data
`endif
);

    localparam int N = depth(SYM_W);
    localparam logic [SYM_W:0] LAST_IDX  = (SYM_W+1)'(N - 1);
    localparam logic [TRY_W:0] MAX_T     = (TRY_W+1)'(MAX_TRIES);

    state_t              state, state_nx;
    logic [SYM_W-1:0]    sym;
    logic                hit;
    logic                accept;
    logic                unique_acc;
    logic                clear_build;
    logic                budget_out;
    logic                last_entry;
    logic [TRY_W:0]      tries_plus;
    logic [SYM_W-1:0]    sbox_mem [N];

    // Bits of the sample outside the symbol slice are intentionally ignored.
    logic unused_in;
    assign unused_in = ^in_data;

    assign sym         = in_data[LSB_SEL +: SYM_W];
    assign in_ready    = (state == FILL);
    assign busy        = (state == FILL);
    assign done        = (state == DONE);
    assign fail        = (state == FAIL);
    assign accept      = in_valid && in_ready;
    assign unique_acc  = accept && !hit;
    // start only matters outside FILL; it wipes the per-build bookkeeping but not the table.
    assign clear_build = start && (state != FILL);
    // One bit wider than tries so the budget compare sees the post-increment count.
    assign tries_plus  = {1'b0, tries} + (TRY_W+1)'(1);
    assign budget_out  = (tries_plus >= MAX_T);
    assign last_entry  = (fill_count == LAST_IDX);

    sbox_seen_map #(.SYM_W(SYM_W)) u_seen (
        .clk    (clk),
        .rst    (rst),
        .clear  (clear_build),
        .set_en (unique_acc),
        .sym    (sym),
        .hit    (hit)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Completing the table wins over running out of tries on the same sample.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE, DONE, FAIL: if (start) state_nx = FILL;
            FILL: begin
                if (unique_acc && last_entry) begin
                    state_nx = DONE;
                end else if (accept && budget_out) begin
                    state_nx = FAIL;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tries      <= '0;
            fill_count <= '0;
        end else if (clear_build) begin
            tries      <= '0;
            fill_count <= '0;
        end else if (accept) begin
            if (tries != '1) begin
                tries <= tries_plus[TRY_W-1:0];
            end
            if (unique_acc) begin
                fill_count <= fill_count + (SYM_W+1)'(1);
            end
        end
    end

    // Read uses the pre-edge contents, so a same-edge write is not visible yet.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                sbox_mem[i] <= '0;
            end
            lookup_data <= '0;
        end else begin
            if (unique_acc) begin
                sbox_mem[fill_count[SYM_W-1:0]] <= sym;
            end
            lookup_data <= sbox_mem[lookup_addr];
        end
    end

`ifdef SBOX_INV_EN
    logic [SYM_W-1:0] inv_mem [N];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                inv_mem[i] <= '0;
            end
            inv_lookup_data <= '0;
        end else begin
            if (unique_acc) begin
                inv_mem[sym] <= fill_count[SYM_W-1:0];
            end
            inv_lookup_data <= inv_mem[inv_lookup_addr];
        end
    end
`endif

endmodule

// File: tb/tb_sbox_builder.sv
// tb/tb_sbox_builder.sv - scoreboard bench for sbox_builder against a queue-based reference model
module tb_sbox_builder;

    localparam int SAMPLE_W  = 8;
    localparam int SYM_W     = 3;
    localparam int LSB_SEL   = 2;
    localparam int TRY_W     = 4;
    localparam int MAX_TRIES = 9;
    localparam int N         = 8;

    logic                clk = 1'b0;
    logic                rst;
    logic                start;
    logic                in_valid;
    logic [SAMPLE_W-1:0] in_data;
    logic                in_ready;
    logic [SYM_W-1:0]    lookup_addr;
    logic [SYM_W-1:0]    lookup_data;
    logic                busy, done, fail;
    logic [SYM_W:0]      fill_count;
    logic [TRY_W-1:0]    tries;
`ifdef SBOX_INV_EN
    logic [SYM_W-1:0]    inv_lookup_addr;
    logic [SYM_W-1:0]    inv_lookup_data;
`endif

    sbox_builder #(
        .SAMPLE_W(SAMPLE_W), .SYM_W(SYM_W), .LSB_SEL(LSB_SEL),
        .TRY_W(TRY_W), .MAX_TRIES(MAX_TRIES)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .lookup_addr(lookup_addr), .lookup_data(lookup_data),
        .busy(busy), .done(done), .fail(fail),
        .fill_count(fill_count), .tries(tries)
`ifdef SBOX_INV_EN
        , .inv_lookup_addr(inv_lookup_addr), .inv_lookup_data(inv_lookup_data)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int rdy, bsy, dn, fl, fill, tr, lk, inv;
    } rec_t;

    rec_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   fire = 1'b0;
    bit   fire_d = 1'b0;
    bit   rdy_at_edge = 1'b0;

    // Reference model: build in progress / finished flags, list of symbols in arrival order.
    bit   m_build, m_done, m_fail;
    int   m_tries;
    int   m_order[$];
    int   m_table[N];
    int   m_inv[N];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        fire_d      <= fire;
        rdy_at_edge <= in_ready;
    end

    // Monitor: one scoreboard record per driven cycle, checked after the edge it describes.
    always @(negedge clk) begin
        if (fire_d) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard: got empty queue expected a record");
            end else begin
                rec_t e;
                e = sb_q.pop_front();
                chk("in_ready",    int'(rdy_at_edge), e.rdy);
                chk("busy",        int'(busy),        e.bsy);
                chk("done",        int'(done),        e.dn);
                chk("fail",        int'(fail),        e.fl);
                chk("fill_count",  int'(fill_count),  e.fill);
                chk("tries",       int'(tries),       e.tr);
                chk("lookup_data", int'(lookup_data), e.lk);
`ifdef SBOX_INV_EN
                chk("inv_lookup_data", int'(inv_lookup_data), e.inv);
`endif
            end
        end
    end

    function automatic bit m_has(input int s);
        foreach (m_order[i]) if (m_order[i] == s) return 1'b1;
        return 1'b0;
    endfunction

    // One clock of stimulus; sym < 0 means a fully random sample, la/ia < 0 random addresses.
    task automatic cycle(input bit r, input bit st, input bit v, input int sym,
                         input int la, input int ia);
        rec_t e;
        int   d, s, lka, iva;
        @(negedge clk);
        d = int'($urandom_range(0, 255));
        if (sym >= 0) d = (d & ~(7 << LSB_SEL)) | (sym << LSB_SEL);
        lka = (la >= 0) ? la : int'($urandom_range(0, N - 1));
        iva = (ia >= 0) ? ia : int'($urandom_range(0, N - 1));
        rst         = r;
        start       = st;
        in_valid    = v;
        in_data     = SAMPLE_W'(d);
        lookup_addr = SYM_W'(lka);
`ifdef SBOX_INV_EN
        inv_lookup_addr = SYM_W'(iva);
`endif
        e.rdy = (!r && m_build) ? 1 : 0;
        e.lk  = r ? 0 : m_table[lka];
        e.inv = r ? 0 : m_inv[iva];
        if (r) begin
            m_build = 0; m_done = 0; m_fail = 0; m_tries = 0;
            m_order.delete();
            foreach (m_table[i]) begin m_table[i] = 0; m_inv[i] = 0; end
        end else if (!m_build && st) begin
            m_build = 1; m_done = 0; m_fail = 0; m_tries = 0;
            m_order.delete();
        end else if (m_build && v) begin
            s = (d >> LSB_SEL) % N;
            if (m_tries < 15) m_tries++;
            if (!m_has(s)) begin
                m_table[m_order.size()] = s;
                m_inv[s] = m_order.size();
                m_order.push_back(s);
            end
            if (m_order.size() == N) begin
                m_build = 0; m_done = 1;
            end else if (m_tries >= MAX_TRIES) begin
                m_build = 0; m_fail = 1;
            end
        end
        e.bsy  = m_build;
        e.dn   = m_done;
        e.fl   = m_fail;
        e.fill = m_order.size();
        e.tr   = m_tries;
        sb_q.push_back(e);
        fire = 1'b1;
    endtask

    int seq_a[9] = '{5, 5, 2, 7, 0, 1, 3, 4, 6};

    initial begin
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0; lookup_addr = '0;
`ifdef SBOX_INV_EN
        inv_lookup_addr = '0;
`endif
        m_build = 0; m_done = 0; m_fail = 0; m_tries = 0;
        foreach (m_table[i]) begin m_table[i] = 0; m_inv[i] = 0; end

        // Reset state, then valid samples offered while IDLE must not count.
        repeat (2) cycle(1, 0, 0, -1, -1, -1);
        repeat (3) cycle(0, 0, 1, -1, -1, -1);

        // Normal build; 9th sample completes the table exactly as the budget runs out,
        // and a start pulse mid-build is ignored.
        cycle(0, 1, 0, -1, -1, -1);
        foreach (seq_a[i]) cycle(0, i == 4, 1, seq_a[i], -1, -1);
        cycle(0, 0, 1, -1, 0, 5);
        cycle(0, 0, 1, -1, 7, 6);
        for (int a = 0; a < N; a++) cycle(0, 0, 0, -1, a, a);

        // Budget exhaustion on repeats, then one more sample that must be refused.
        cycle(0, 1, 0, -1, -1, -1);
        repeat (MAX_TRIES) cycle(0, 0, 1, 1, -1, -1);
        cycle(0, 0, 1, 5, -1, -1);

        // Restart into identity table, with lookups showing stale then new entries.
        cycle(0, 1, 0, -1, -1, -1);
        for (int s = 0; s < N; s++) cycle(0, 0, 1, s, s, -1);
        for (int a = 0; a < N; a++) cycle(0, 0, 0, -1, a, a);

        // Reset in the middle of a build.
        cycle(0, 1, 0, -1, -1, -1);
        repeat (3) cycle(0, 0, 1, -1, -1, -1);
        cycle(1, 0, 1, -1, -1, -1);
        cycle(0, 0, 0, -1, -1, -1);

        // Random builds with random start pulses and gaps in valid.
        repeat (25) begin
            cycle(0, 1, 0, -1, -1, -1);
            repeat (12) cycle(0, $urandom_range(0, 9) == 0, $urandom_range(0, 3) != 0,
                              -1, -1, -1);
        end

        @(negedge clk);
        fire = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending records expected 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
